// File: rtl/amba_ahb_pkg.sv
// ---------------------------------------------------------------------------
// amba_ahb_pkg
// Shared AHB-Lite encodings for the nanorv32 AHB master and the SSRAM slave.
//   htrans_e   : HTRANS transfer types (IDLE/BUSY/NONSEQ/SEQ)
//   HSIZE_*    : HSIZE encodings for byte/halfword/word
//   HRESP_*    : HRESP encodings (AHB-Lite single-bit form)
// ---------------------------------------------------------------------------
package amba_ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   localparam logic [2:0] HSIZE_8  = 3'b000;
   localparam logic [2:0] HSIZE_16 = 3'b001;
   localparam logic [2:0] HSIZE_32 = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/nanorv32_ahb_master.sv
// ---------------------------------------------------------------------------
// nanorv32_ahb_master
// Bridges the core's valid/ready memory port onto an AHB-Lite master.
// Single NONSEQ transfers; the address phase of request N+1 overlaps the
// data phase of request N. One registered response per request, in order.
//
// Ports
//   HCLK, HRESET          clock, synchronous active-high reset
//   req_valid/req_ready   core request handshake
//   req_addr/we/size/wdata request payload (wdata lane-replicated)
//   rsp_valid/rdata/err   one-cycle response pulse (rdata 0 for writes)
//   HADDR/HTRANS/HSIZE/HWRITE/HWDATA   AHB master outputs
//   HREADY/HRDATA/HRESP   AHB slave return
// ---------------------------------------------------------------------------
module nanorv32_ahb_master
   import amba_ahb_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic          HCLK,
   input  logic          HRESET,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_addr,
   input  logic          req_we,
   input  logic [1:0]    req_size,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err,
   output logic [AW-1:0] HADDR,
   output logic [1:0]    HTRANS,
   output logic [2:0]    HSIZE,
   output logic          HWRITE,
   output logic [31:0]   HWDATA,
   input  logic          HREADY,
   input  logic [31:0]   HRDATA,
   input  logic          HRESP
);

   typedef enum logic {ST_NORMAL, ST_ERR1} err_state_e;

   err_state_e    state_q, state_d;

   // address stage
   logic          a_valid_q, a_valid_d;
   logic [AW-1:0] a_addr_q,  a_addr_d;
   logic [1:0]    a_size_q,  a_size_d;
   logic          a_we_q,    a_we_d;
   logic [31:0]   a_wdata_q, a_wdata_d;
   // data stage
   logic          d_valid_q, d_valid_d;
   logic          d_we_q,    d_we_d;
   logic [31:0]   d_wdata_q, d_wdata_d;
   // response register
   logic          rsp_valid_q, rsp_valid_d;
   logic [31:0]   rsp_rdata_q, rsp_rdata_d;
   logic          rsp_err_q,   rsp_err_d;

   logic in_err, err_first, err_done, advance, retire, accept;

   // First cycle of a two-cycle ERROR: slave flags ERROR with HREADY low.
   assign in_err    = (state_q == ST_ERR1);
   assign err_first = d_valid_q & (HRESP == HRESP_ERROR) & ~HREADY;
   assign err_done  = in_err & (HRESP == HRESP_ERROR) & HREADY;
   assign advance   = HREADY & ~in_err;
   // In ERR1's final cycle D completes but A stays put, so the cancelled
   // address is re-driven next cycle rather than being treated as sampled.
   assign retire    = (advance | err_done) & d_valid_q;

   // An empty A may load even during a wait state; the bus only samples it
   // once HREADY comes back.
   assign req_ready = ~in_err & ~err_first & (~a_valid_q | HREADY);
   assign accept    = req_valid & req_ready;

   assign HTRANS    = (a_valid_q & ~in_err) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HADDR     = a_addr_q;
   assign HSIZE     = {1'b0, a_size_q};
   assign HWRITE    = a_we_q;
   assign HWDATA    = d_wdata_q;

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   always_comb begin
      state_d     = state_q;
      a_valid_d   = a_valid_q;
      a_addr_d    = a_addr_q;
      a_size_d    = a_size_q;
      a_we_d      = a_we_q;
      a_wdata_d   = a_wdata_q;
      d_valid_d   = d_valid_q;
      d_we_d      = d_we_q;
      d_wdata_d   = d_wdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = 32'h0;
      rsp_err_d   = 1'b0;

      unique case (state_q)
         ST_NORMAL: if (err_first) state_d = ST_ERR1;
         ST_ERR1:   if (err_done)  state_d = ST_NORMAL;
         default:   state_d = ST_NORMAL;
      endcase

      if (retire) begin
         rsp_valid_d = 1'b1;
         rsp_rdata_d = d_we_q ? 32'h0 : HRDATA;
         rsp_err_d   = HRESP;
      end

      if (advance) begin
         d_valid_d = a_valid_q;
         d_we_d    = a_we_q;
         d_wdata_d = a_wdata_q;
         a_valid_d = 1'b0;
      end else if (err_done) begin
         d_valid_d = 1'b0;
      end

      if (accept) begin
         a_valid_d = 1'b1;
         a_addr_d  = req_addr;
         a_size_d  = req_size;
         a_we_d    = req_we;
         a_wdata_d = req_wdata;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q     <= ST_NORMAL;
         a_valid_q   <= 1'b0;
         a_addr_q    <= '0;
         a_size_q    <= 2'b00;
         a_we_q      <= 1'b0;
         a_wdata_q   <= 32'h0;
         d_valid_q   <= 1'b0;
         d_we_q      <= 1'b0;
         d_wdata_q   <= 32'h0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_valid_q   <= a_valid_d;
         a_addr_q    <= a_addr_d;
         a_size_q    <= a_size_d;
         a_we_q      <= a_we_d;
         a_wdata_q   <= a_wdata_d;
         d_valid_q   <= d_valid_d;
         d_we_q      <= d_we_d;
         d_wdata_q   <= d_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_nanorv32_ahb_master.sv
// ---------------------------------------------------------------------------
// tb_nanorv32_ahb_master
// Directed scenarios for the AHB master followed by a randomized run where a
// small AHB slave memory serves the bus and an in-order reference memory
// predicts every response.
// ---------------------------------------------------------------------------
module tb_nanorv32_ahb_master;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic        HWRITE, HREADY, HRESP;

   int tests = 0;
   int fails = 0;

   always #5 HCLK = ~HCLK;

   nanorv32_ahb_master #(.AW(32)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_we(req_we), .req_size(req_size), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
      .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h, required %h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic put_req(input logic we, input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] wd);
      req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz; req_wdata = wd;
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [7:0] a, input logic [1:0] sz);
      logic [31:0] m;
      int sh;
      if (sz == 2'd0) begin
         sh = 8 * int'(a[1:0]);
         m  = 32'h0000_00FF << sh;
      end else if (sz == 2'd1) begin
         sh = 16 * int'(a[1]);
         m  = 32'h0000_FFFF << sh;
      end else begin
         m = 32'hFFFF_FFFF;
      end
      return (old & ~m) | (wd & m);
   endfunction

   logic [31:0] smem [64];   // slave-side memory
   logic [31:0] rmem [64];   // reference memory
   logic [31:0] exp_q [$];   // expected rdata, one per accepted request

   initial begin
      logic [31:0] hw0;
      logic        dp_valid, dp_we;
      logic [7:0]  dp_addr, ra;
      logic [1:0]  dp_size, sz;
      logic [31:0] b, wd, e;
      logic        we;
      int          acc, nrsp;

      HRESET = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
      req_size = 2'd0; req_wdata = 32'h0; HREADY = 1'b1; HRDATA = 32'h0; HRESP = 1'b0;
      step(); step();

      // ---- reset state
      HRESET = 1'b0;
      #1;
      check("rst_htrans", 32'(HTRANS), 32'h0);
      check("rst_haddr",  HADDR, 32'h0);
      check("rst_hsize",  32'(HSIZE), 32'h0);
      check("rst_hwrite", 32'(HWRITE), 32'h0);
      check("rst_hwdata", HWDATA, 32'h0);
      check("rst_rspv",   32'(rsp_valid), 32'h0);
      check("rst_rdata",  rsp_rdata, 32'h0);
      check("rst_err",    32'(rsp_err), 32'h0);
      check("rst_ready",  32'(req_ready), 32'h1);
      step();

      // ---- single read of 0x100, zero wait states
      put_req(1'b0, 32'h100, 2'd2, 32'h0);
      HRDATA = 32'hCAFE_F00D;
      step();
      req_valid = 1'b0;
      #1;
      check("rd_htrans", 32'(HTRANS), 32'h2);
      check("rd_haddr",  HADDR, 32'h100);
      check("rd_hwrite", 32'(HWRITE), 32'h0);
      step();
      check("rd_c1_rspv", 32'(rsp_valid), 32'h0);
      step();
      check("rd_c2_rspv", 32'(rsp_valid), 32'h1);
      check("rd_c2_data", rsp_rdata, 32'hCAFE_F00D);
      check("rd_c2_err",  32'(rsp_err), 32'h0);
      step();
      check("rd_c3_rspv", 32'(rsp_valid), 32'h0);

      // ---- four back-to-back word writes
      HRDATA = 32'hFFFF_FFFF;
      for (int c = 0; c < 8; c++) begin
         if (c < 4) put_req(1'b1, 32'(4 * c), 2'd2, 32'(c + 1));
         else req_valid = 1'b0;
         #1;
         if (c < 4) check("wr4_ready", 32'(req_ready), 32'h1);
         if (c >= 1 && c <= 4) begin
            check("wr4_htrans", 32'(HTRANS), 32'h2);
            check("wr4_haddr",  HADDR, 32'(4 * (c - 1)));
            check("wr4_hwrite", 32'(HWRITE), 32'h1);
         end else begin
            check("wr4_idle", 32'(HTRANS), 32'h0);
         end
         if (c >= 2 && c <= 5) check("wr4_hwdata", HWDATA, 32'(c - 1));
         check("wr4_rspv", 32'(rsp_valid), (c >= 3 && c <= 6) ? 32'h1 : 32'h0);
         if (c >= 3 && c <= 6) begin
            check("wr4_err",   32'(rsp_err), 32'h0);
            check("wr4_rdata", rsp_rdata, 32'h0);
         end
         step();
      end

      // ---- byte write 0x103 then halfword read 0x102
      put_req(1'b1, 32'h103, 2'd0, 32'hABAB_ABAB);
      step();
      put_req(1'b0, 32'h102, 2'd1, 32'h0);
      #1;
      check("bh_ready",  32'(req_ready), 32'h1);
      check("bh_hsize0", 32'(HSIZE), 32'h0);
      check("bh_haddr0", HADDR, 32'h103);
      check("bh_hwrite0", 32'(HWRITE), 32'h1);
      step();
      req_valid = 1'b0;
      #1;
      check("bh_hsize1", 32'(HSIZE), 32'h1);
      check("bh_haddr1", HADDR, 32'h102);
      check("bh_hwrite1", 32'(HWRITE), 32'h0);
      check("bh_hwdata", HWDATA, 32'hABAB_ABAB);
      step();
      HRDATA = 32'h1122_3344;
      #1;
      check("bh_wr_rspv", 32'(rsp_valid), 32'h1);
      check("bh_wr_rdata", rsp_rdata, 32'h0);
      step();
      check("bh_rd_rspv", 32'(rsp_valid), 32'h1);
      check("bh_rd_rdata", rsp_rdata, 32'h1122_3344);
      step();

      // ---- read 0x200 with three wait states, write 0x204 queued behind it
      put_req(1'b0, 32'h200, 2'd2, 32'h0);
      step();
      put_req(1'b1, 32'h204, 2'd2, 32'hDEAD_BEEF);
      #1;
      check("ws_ready_a", 32'(req_ready), 32'h1);
      step();
      put_req(1'b0, 32'h208, 2'd2, 32'h0);
      HREADY = 1'b0;
      #1;
      hw0 = HWDATA;
      for (int w = 0; w < 3; w++) begin
         if (w > 0) #1;
         check("ws_ready",  32'(req_ready), 32'h0);
         check("ws_htrans", 32'(HTRANS), 32'h2);
         check("ws_haddr",  HADDR, 32'h204);
         check("ws_hwrite", 32'(HWRITE), 32'h1);
         check("ws_hsize",  32'(HSIZE), 32'h2);
         check("ws_hwdata", HWDATA, hw0);
         check("ws_rspv",   32'(rsp_valid), 32'h0);
         step();
      end
      HREADY = 1'b1;
      HRDATA = 32'h1234_5678;
      #1;
      check("ws_ready_b", 32'(req_ready), 32'h1);
      check("ws_haddr_b", HADDR, 32'h204);
      check("ws_rspv_b",  32'(rsp_valid), 32'h0);
      step();
      req_valid = 1'b0;
      HRDATA = 32'hFFFF_FFFF;
      #1;
      check("ws_rsp_rspv", 32'(rsp_valid), 32'h1);
      check("ws_rsp_data", rsp_rdata, 32'h1234_5678);
      check("ws_rsp_err",  32'(rsp_err), 32'h0);
      check("ws_haddr_c",  HADDR, 32'h208);
      check("ws_hwdata_c", HWDATA, 32'hDEAD_BEEF);
      step();
      HRDATA = 32'h0BAD_F00D;
      #1;
      check("ws_wr_rspv",  32'(rsp_valid), 32'h1);
      check("ws_wr_rdata", rsp_rdata, 32'h0);
      step();
      check("ws_rd2_rspv",  32'(rsp_valid), 32'h1);
      check("ws_rd2_rdata", rsp_rdata, 32'h0BAD_F00D);
      step();

      // ---- two-cycle ERROR on write 0x300 with read 0x304 pending in A
      put_req(1'b1, 32'h300, 2'd2, 32'h5);
      step();
      put_req(1'b0, 32'h304, 2'd2, 32'h0);
      step();
      req_valid = 1'b0;
      HREADY = 1'b0; HRESP = 1'b1;
      #1;
      check("err_ready1", 32'(req_ready), 32'h0);
      step();
      HREADY = 1'b1; HRESP = 1'b1;
      #1;
      check("err_idle",   32'(HTRANS), 32'h0);
      check("err_ready2", 32'(req_ready), 32'h0);
      check("err_rspv0",  32'(rsp_valid), 32'h0);
      step();
      HRESP = 1'b0;
      #1;
      check("err_rspv",   32'(rsp_valid), 32'h1);
      check("err_rsperr", 32'(rsp_err), 32'h1);
      check("err_reissue", 32'(HTRANS), 32'h2);
      check("err_haddr",  HADDR, 32'h304);
      step();
      HRDATA = 32'h55AA_55AA;
      #1;
      check("err_once",   32'(HTRANS), 32'h0);
      step();
      check("err_rd_rspv", 32'(rsp_valid), 32'h1);
      check("err_rd_err",  32'(rsp_err), 32'h0);
      check("err_rd_data", rsp_rdata, 32'h55AA_55AA);
      step();
      check("err_done_rspv", 32'(rsp_valid), 32'h0);

      // ---- reset during a read's data phase
      put_req(1'b0, 32'h400, 2'd2, 32'h0);
      step();
      req_valid = 1'b0;
      step();
      HRESET = 1'b1;
      step();
      HRESET = 1'b0;
      #1;
      check("rstd_htrans", 32'(HTRANS), 32'h0);
      check("rstd_rspv",   32'(rsp_valid), 32'h0);
      for (int k = 0; k < 3; k++) begin
         step();
         check("rstd_norsp", 32'(rsp_valid), 32'h0);
      end

      // ---- randomized traffic against the reference memory
      for (int i = 0; i < 64; i++) begin
         smem[i] = $urandom;
         rmem[i] = smem[i];
      end
      dp_valid = 1'b0; dp_we = 1'b0; dp_addr = 8'h0; dp_size = 2'd0;
      acc = 0; nrsp = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         HRESP  = 1'b0;
         HREADY = dp_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
         HRDATA = (dp_valid && !dp_we) ? smem[dp_addr[7:2]] : $urandom;
         if (cyc < 540 && $urandom_range(0, 3) != 0) begin
            sz = 2'($urandom_range(0, 2));
            ra = 8'($urandom_range(0, 255));
            if (sz == 2'd1) ra[0] = 1'b0;
            if (sz == 2'd2) ra[1:0] = 2'b00;
            b  = $urandom;
            wd = (sz == 2'd0) ? {4{b[7:0]}} : (sz == 2'd1) ? {2{b[15:0]}} : b;
            we = 1'($urandom_range(0, 1));
            put_req(we, {24'h0, ra}, sz, wd);
         end else begin
            req_valid = 1'b0;
         end
         #1;
         if (rsp_valid) begin
            nrsp++;
            check("rnd_pending", 32'(exp_q.size() > 0), 32'h1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("rnd_rdata", rsp_rdata, e);
               check("rnd_err",   32'(rsp_err), 32'h0);
            end
         end
         if (req_valid && req_ready) begin
            acc++;
            if (req_we) begin
               rmem[req_addr[7:2]] = merge(rmem[req_addr[7:2]], req_wdata, req_addr[7:0], req_size);
               exp_q.push_back(32'h0);
            end else begin
               exp_q.push_back(rmem[req_addr[7:2]]);
            end
         end
         // slave side: complete the data phase, capture the next address phase
         if (HREADY) begin
            if (dp_valid && dp_we)
               smem[dp_addr[7:2]] = merge(smem[dp_addr[7:2]], HWDATA, dp_addr, dp_size);
            dp_valid = (HTRANS == 2'b10);
            dp_we    = HWRITE;
            dp_addr  = HADDR[7:0];
            dp_size  = HSIZE[1:0];
         end
         step();
      end
      check("rnd_q_empty", 32'(exp_q.size()), 32'h0);
      check("rnd_count",   32'(nrsp), 32'(acc));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
